// File: rtl/ro_count_reader.sv
// Measurement sequencer for a ring-oscillator edge counter:
// clear, gate for a window, settle, capture a stable count, hand off.
module ro_count_reader #(
  parameter int WINDOW_WIDTH  = 32,
  parameter int CLEAR_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_TRIES     = 8
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  output logic                    ro_enable,
  output logic                    counter_reset,
  input  logic [31:0]             count,
  output logic [31:0]             result,
  output logic                    result_err,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy
);

  localparam int CW = 16;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] STL_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TRY_LAST = CW'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [WINDOW_WIDTH-1:0] win_q, win_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [31:0]             samp_q, samp_d;
  logic [31:0]             result_q, result_d;
  logic                    err_q, err_d;
  logic                    ro_en_q, ro_en_d;
  logic                    crst_q, crst_d;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cyc_d    = cyc_q;
    samp_d   = samp_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          win_d   = window_len;
          cyc_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cyc_q == CLR_LAST) begin
          cyc_d   = '0;
          state_d = (win_q == '0) ? S_SETTLE : S_RUN;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_RUN: begin
        // Count down so an all-ones window never wraps.
        if (win_q == WINDOW_WIDTH'(1)) begin
          state_d = S_SETTLE;
        end
        win_d = win_q - 1'b1;
      end
      S_SETTLE: begin
        if (cyc_q == STL_LAST) begin
          cyc_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        samp_d = count;
        if (cyc_q != '0 && count == samp_q) begin
          state_d  = S_DONE;
          result_d = count;
          err_d    = 1'b0;
        end else if (cyc_q == TRY_LAST) begin
          state_d  = S_DONE;
          result_d = count;
          err_d    = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ro_en_d = (state_d == S_RUN);
    crst_d  = (state_d == S_CLEAR);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      cyc_q    <= '0;
      samp_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      ro_en_q  <= 1'b0;
      crst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cyc_q    <= cyc_d;
      samp_q   <= samp_d;
      result_q <= result_d;
      err_q    <= err_d;
      ro_en_q  <= ro_en_d;
      crst_q   <= crst_d;
    end
  end

  assign ro_enable     = ro_en_q;
  assign counter_reset = crst_q;
  assign result        = result_q;
  assign result_err    = err_q;
  assign result_valid  = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);

endmodule

// File: doc/ro_count_reader.md
Name: ro_count_reader

Overview:
- Measurement controller for the other end of the ring-oscillator edge counter. The counter is a DSP-based free-running 32-bit up-counter with a synchronous active-high reset.
- Per measurement, this block:
  - clears the counter;
  - gates the oscillator for a programmable window of system clocks;
  - stops the oscillator and waits for it to settle;
  - reads the now-static count with a stability check;
  - presents the result on a valid/ready interface.
- Sits between the counter instances and the readout/AXI logic.

Parameters:
- WINDOW_WIDTH, 32, width of window_len (gate length in CLK cycles).
- CLEAR_CYCLES, 4, cycles counter_reset is held high before gating (≥1).
- SETTLE_CYCLES, 16, cycles after ro_enable falls before sampling count (≥1).
- MAX_TRIES, 8, maximum capture samples before declaring the count unstable (≥2).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request; honoured only in IDLE.
- window_len  in  WINDOW_WIDTH  gate length; latched on an accepted start.
- ro_enable  out  1  enables the ring oscillator (counter clock source).
- counter_reset  out  1  drives the counter's reset input.
- count  in  32  counter value; quasi-static once the oscillator is stopped.
- result  out  32  captured count.
- result_err  out  1  capture failed stability check; qualified by result_valid.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE.
  - ro_enable=0, counter_reset=0, result=0, result_err=0, result_valid=0, busy=0.
  - Internal counters and latched window are cleared.
  - Reset mid-measurement aborts immediately: ro_enable falls on the next edge and any pending result is discarded.
- States: IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE.
- IDLE:
  - start=1 latches window_len and moves to CLEAR.
  - busy, counter_reset and ro_enable become 1/1/0 on the following cycle.
- CLEAR:
  - counter_reset=1 for exactly CLEAR_CYCLES cycles, then RUN.
  - If latched window_len=0, go directly to SETTLE; ro_enable is never asserted.
- RUN:
  - ro_enable=1 for exactly window_len cycles, registered output; counter_reset=0.
  - Then SETTLE.
- SETTLE:
  - ro_enable=0 for exactly SETTLE_CYCLES cycles, then CAPTURE.
- CAPTURE:
  - Register count every cycle, compare each sample with the previous one.
  - The first sample has no predecessor and never matches.
  - Two consecutive equal samples: result=that value, result_err=0, go to DONE.
  - MAX_TRIES samples with no match: result=last sample, result_err=1, go to DONE.
- DONE:
  - result_valid=1; result and result_err are held stable.
  - A cycle with result_valid=1 and result_ready=1 is the transfer; the next cycle is IDLE with result_valid=0.
  - result_ready asserted before DONE has no effect.
- start while busy=1 is ignored; it is neither queued nor does it restart.
- start and the transfer in the same cycle: the start is ignored, because the block is still in DONE.
- The counter is not cleared after readout. count keeps its value until the next CLEAR, so software may re-read the counter directly.
- Window counter:
  - WINDOW_WIDTH bits, counts down from the latched value.
  - A maximum window_len (all ones) must work without wrap.
- Count width: no arithmetic on count; the 32-bit value passes through unchanged.
  - Counter wrap during a long window is not detected by this block; it is the caller's responsibility to size window_len.
- Total latency, accepted start to first result_valid (no-err case): 1 + CLEAR_CYCLES + window_len + SETTLE_CYCLES + 2 cycles. This figure is exact and is checked by the bench.

Test Plan:
- Basic measurement (defaults; model counter clocked by CLK&ro_enable, reset by counter_reset):
  - Stimulus: start with window_len=100, result_ready tied 1.
  - Response: ro_enable high exactly 100 cycles; result=100, result_err=0; result_valid one cycle, at 1+4+100+16+2=123 cycles after start.
- Zero window:
  - Stimulus: window_len=0.
  - Response: ro_enable never high; counter_reset high 4 cycles; result=0, result_err=0.
- Unstable count:
  - Stimulus: model count increments every cycle during CAPTURE.
  - Response: after 8 samples, result_err=1 and result equals the 8th sample.
- Backpressure and ignored start:
  - Stimulus: result_ready=0 for 20 cycles after result_valid; pulse start mid-RUN and during DONE.
  - Response: result stable for all 20 cycles; exactly one measurement occurs; IDLE is reached one cycle after ready.
- Reset mid-RUN:
  - Stimulus: assert reset at window cycle 50 of 100.
  - Response: next edge gives ro_enable=0, busy=0, result_valid=0; a subsequent start with window_len=10 yields result=10.
- Large window:
  - Stimulus: window_len=32'hFFFF_FFFF with a forced/accelerated down-counter check.
  - Response: no early termination; the window counter reaches 0 before the state advances.
